// File: rtl/tx_pattern_gen_pkg.sv
// Shared types and constants for the UART TX test-pattern source.
package tx_test_pkg;

  localparam int unsigned T1S_50MHZ = 50_000_000;

  typedef enum logic [1:0] {
    PAT_FIXED,
    PAT_INCR,
    PAT_WALK1,
    PAT_LFSR
  } tx_pat_mode_e;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_gen_state_e;

endpackage

// File: rtl/tx_pattern_gen_if.sv
// Request/acknowledge link between the pattern source and a UART TX core.
interface tx_pattern_gen_if #(
  parameter int unsigned DATA_W = 8
);
  logic              tx_en_sig;
  logic [DATA_W-1:0] tx_data;
  logic              tx_done_sig;

  modport master (output tx_en_sig, output tx_data, input tx_done_sig);
  modport slave  (input tx_en_sig, input tx_data, output tx_done_sig);
endinterface

// File: rtl/tx_tick_gen.sv
// Free-running period counter; pulses tick on the last count of each period.
module tx_tick_gen
  import tx_test_pkg::*;
#(
  parameter int unsigned PERIOD_CYCLES = T1S_50MHZ
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(PERIOD_CYCLES);
  localparam logic [CntW-1:0] Last = CntW'(PERIOD_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == Last);
    cnt_d = cnt_q + CntW'(1);
    if (!enable || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/tx_pattern_gen.sv
// Periodic burst pattern source for UART bring-up and soak tests, with a done-timeout watchdog.
module tx_pattern_gen
  import tx_test_pkg::*;
#(
  parameter int unsigned       PERIOD_CYCLES  = T1S_50MHZ,
  parameter int unsigned       DATA_W         = 8,
  parameter int unsigned       BURST_LEN      = 1,
  parameter logic [31:0]       SEED           = 32'h31,
  parameter logic [DATA_W-1:0] LFSR_TAPS      = DATA_W'(8'hB8),
  parameter int unsigned       TIMEOUT_CYCLES = 1_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  tx_pat_mode_e            mode,
  input  logic                    err_clr,
  tx_pattern_gen_if.master        tx,
  output logic                    busy,
  output logic [15:0]             sent_count,
  output logic                    timeout_err
);

  localparam int unsigned WordW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int unsigned WdW   = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [DATA_W-1:0] One    = DATA_W'(1);
  localparam logic [DATA_W-1:0] SeedW  = DATA_W'(SEED);
  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [DATA_W-1:0] SeedNz = (SeedW == '0) ? One : SeedW;

  function automatic logic [DATA_W-1:0] seed_of(input tx_pat_mode_e m);
    return (m == PAT_WALK1) ? One : (m == PAT_LFSR) ? SeedNz : SeedW;
  endfunction

  function automatic logic [DATA_W-1:0] advance(input tx_pat_mode_e m,
                                                input logic [DATA_W-1:0] p);
    logic [DATA_W-1:0] r;
    unique case (m)
      PAT_INCR:  r = p + One;
      PAT_WALK1: r = (p << 1) | (p >> (DATA_W - 1));
      PAT_LFSR:  r = (p >> 1) ^ (p[0] ? LFSR_TAPS : '0);
      default:   r = p;
    endcase
    return r;
  endfunction

  tx_gen_state_e     state_q, state_d;
  tx_pat_mode_e      mode_q, mode_d;
  logic [DATA_W-1:0] pat_q, pat_d;
  logic [WordW-1:0]  words_q, words_d;
  logic [WdW-1:0]    wd_q, wd_d;
  logic [15:0]       sent_q, sent_d;
  logic              err_q, err_d;
  logic              tick;

  assign busy          = (state_q != IDLE);
  assign tx.tx_en_sig  = (state_q == SEND);
  assign tx.tx_data    = pat_q;
  assign sent_count    = sent_q;
  assign timeout_err   = err_q;

  // Keep the period counter alive until an in-flight burst finishes.
  tx_tick_gen #(
    .PERIOD_CYCLES(PERIOD_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .enable(enable | busy),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pat_d   = pat_q;
    words_d = words_q;
    wd_d    = wd_q;
    sent_d  = sent_q;
    err_d   = err_clr ? 1'b0 : err_q;
    unique case (state_q)
      IDLE: begin
        if (tick) begin
          mode_d  = mode;
          if (mode != mode_q) pat_d = seed_of(mode);
          words_d = WordW'(BURST_LEN - 1);
          wd_d    = '0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx.tx_done_sig) begin
          sent_d = sent_q + 16'd1;
          pat_d  = advance(mode_q, pat_q);
          if (words_q != '0) begin
            words_d = words_q - WordW'(1);
            state_d = GAP;
          end else begin
            state_d = IDLE;
          end
        end else if (wd_q == WdW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          wd_d = wd_q + WdW'(1);
        end
      end
      GAP: begin
        wd_d    = '0;
        state_d = SEND;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= PAT_FIXED;
      pat_q   <= SeedNz;
      words_q <= '0;
      wd_q    <= '0;
      sent_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pat_q   <= pat_d;
      words_q <= words_d;
      wd_q    <= wd_d;
      sent_q  <= sent_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_tx_pattern_gen.sv
// Scoreboard bench: expected words are queued by the stimulus, a monitor pops them on each en rise.
module tb_tx_pattern_gen;
  import tx_test_pkg::*;

  localparam int unsigned PERIOD = 16;
  localparam int unsigned BURST  = 3;
  localparam int unsigned TMO    = 32;
  localparam int unsigned DW     = 8;

  typedef struct {
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
  logic         enable_w = 1'b0;
  logic         err_clr = 1'b0;
  tx_pat_mode_e mode = PAT_FIXED;
  logic         busy, timeout_err, busy_w, timeout_err_w;
  logic [15:0]  sent_count, sent_count_w;

  exp_t exp_q[$];
  exp_t exp_w_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc;
  int   ack_delay = 5;
  bit   ack_on = 1'b1;

  tx_pattern_gen_if #(.DATA_W(DW)) tx ();
  tx_pattern_gen_if #(.DATA_W(DW)) tx_w ();

  tx_pattern_gen #(
    .PERIOD_CYCLES(PERIOD), .DATA_W(DW), .BURST_LEN(BURST), .SEED(32'h31),
    .LFSR_TAPS(8'hB8), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mode(mode), .err_clr(err_clr),
    .tx(tx.master), .busy(busy), .sent_count(sent_count), .timeout_err(timeout_err)
  );

  // Second instance exercises the incrementing wrap from a seed near all-ones.
  tx_pattern_gen #(
    .PERIOD_CYCLES(PERIOD), .DATA_W(DW), .BURST_LEN(BURST), .SEED(32'hFE),
    .LFSR_TAPS(8'hB8), .TIMEOUT_CYCLES(TMO)
  ) dut_w (
    .clk(clk), .rst_n(rst_n), .enable(enable_w), .mode(PAT_INCR), .err_clr(1'b0),
    .tx(tx_w.master), .busy(busy_w), .sent_count(sent_count_w), .timeout_err(timeout_err_w)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic push(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  task automatic push_w(input logic [7:0] d, input int c);
    exp_t e;
    e.data = d;
    e.cyc  = c;
    exp_w_q.push_back(e);
  endtask

  task automatic assert_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // UART core model: acks ack_delay cycles after en rises.
  initial begin
    int hi;
    hi = 0;
    tx.tx_done_sig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx.tx_done_sig = 1'b0;
      if (rst_n && tx.tx_en_sig) begin
        if (ack_on && hi == ack_delay) tx.tx_done_sig = 1'b1;
        hi++;
      end else begin
        hi = 0;
      end
    end
  end

  initial begin
    int hi;
    hi = 0;
    tx_w.tx_done_sig = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_w.tx_done_sig = 1'b0;
      if (rst_n && tx_w.tx_en_sig) begin
        if (hi == 5) tx_w.tx_done_sig = 1'b1;
        hi++;
      end else begin
        hi = 0;
      end
    end
  end

  initial begin
    logic       prev;
    logic [7:0] held;
    exp_t       e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (tx.tx_en_sig && !prev) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got %0h at cycle %0d, expected no word", tx.tx_data, cyc);
        end else begin
          e = exp_q.pop_front();
          check("word_data", tx.tx_data, e.data);
          check("word_cycle", cyc, e.cyc);
          held = tx.tx_data;
        end
      end
      if (tx.tx_en_sig && tx.tx_done_sig) check("data_stable", tx.tx_data, held);
      prev = tx.tx_en_sig;
    end
  end

  initial begin
    logic       prev;
    logic [7:0] held;
    exp_t       e;
    prev = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (tx_w.tx_en_sig && !prev) begin
        if (exp_w_q.size() == 0) begin
          checks++;
          $display("FAIL w_unexpected_word: got %0h at cycle %0d, expected no word",
                   tx_w.tx_data, cyc);
        end else begin
          e = exp_w_q.pop_front();
          check("w_word_data", tx_w.tx_data, e.data);
          check("w_word_cycle", cyc, e.cyc);
          held = tx_w.tx_data;
        end
      end
      if (tx_w.tx_en_sig && tx_w.tx_done_sig) check("w_data_stable", tx_w.tx_data, held);
      prev = tx_w.tx_en_sig;
    end
  end

  initial begin
    #50000;
    $display("FAIL sim_timeout: time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_en", tx.tx_en_sig, 0);
    check("rst_busy", busy, 0);
    check("rst_sent", sent_count, 0);
    check("rst_err", timeout_err, 0);
    check("rst_data", tx.tx_data, 8'h31);
    check("rst_data_w", tx_w.tx_data, 8'hFE);

    // Fixed bursts on dut, incrementing wrap on dut_w
    push(8'h31, 16); push(8'h31, 23); push(8'h31, 30);
    push(8'h31, 48); push(8'h31, 55); push(8'h31, 62);
    push_w(8'hFE, 16); push_w(8'hFF, 23); push_w(8'h00, 30);
    push_w(8'h01, 48); push_w(8'h02, 55); push_w(8'h03, 62);
    enable = 1'b1;
    enable_w = 1'b1;
    rst_n = 1'b1;
    wait_cyc(35);
    check("busy_last_word", busy, 1);
    wait_cyc(36);
    check("busy_after_burst", busy, 0);
    check("sent_after_burst", sent_count, 3);
    wait_cyc(65);
    enable_w = 1'b0;
    wait_cyc(68);
    check("sent_two_bursts", sent_count, 6);
    check("w_sent_two_bursts", sent_count_w, 6);

    // Walking one, then LFSR selected mid-burst (takes effect next burst)
    mode = PAT_WALK1;
    push(8'h01, 80); push(8'h02, 87); push(8'h04, 94);
    push(8'h08, 112); push(8'h10, 119); push(8'h20, 126);
    wait_cyc(120);
    mode = PAT_LFSR;
    push(8'h31, 144); push(8'hA0, 151); push(8'h50, 158);
    wait_cyc(150);
    enable = 1'b0;
    wait_cyc(200);
    check("sent_five_bursts", sent_count, 15);
    check("idle_after_disable", busy, 0);
    check("w_idle_after_disable", sent_count_w, 6);

    // Watchdog: no ack, word is retried unchanged on a later burst
    assert_reset();
    check("rst_clears_sent", sent_count, 0);
    ack_on = 1'b0;
    mode = PAT_INCR;
    enable = 1'b1;
    push(8'h31, 16);
    push(8'h31, 64); push(8'h32, 71); push(8'h33, 78);
    rst_n = 1'b1;
    wait_cyc(47);
    check("en_before_timeout", tx.tx_en_sig, 1);
    wait_cyc(48);
    check("en_after_timeout", tx.tx_en_sig, 0);
    check("timeout_err_set", timeout_err, 1);
    check("timeout_sent", sent_count, 0);
    check("timeout_busy", busy, 0);
    wait_cyc(50);
    err_clr = 1'b1;
    wait_cyc(51);
    err_clr = 1'b0;
    check("err_cleared", timeout_err, 0);
    ack_on = 1'b1;
    wait_cyc(84);
    check("retry_sent", sent_count, 3);

    // Done on the watchdog's last cycle wins; long burst drops ticks
    assert_reset();
    ack_delay = 31;
    push(8'h31, 16); push(8'h32, 49); push(8'h33, 82); push(8'h34, 128);
    rst_n = 1'b1;
    wait_cyc(114);
    check("late_done_no_err", timeout_err, 0);
    check("late_done_sent", sent_count, 3);
    check("late_done_idle", busy, 0);
    wait_cyc(130);

    // Asynchronous reset mid-SEND
    assert_reset();
    ack_delay = 5;
    mode = PAT_FIXED;
    push(8'h31, 16);
    rst_n = 1'b1;
    wait_cyc(18);
    check("en_mid_send", tx.tx_en_sig, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_en", tx.tx_en_sig, 0);
    check("async_rst_busy", busy, 0);
    repeat (2) @(negedge clk);
    check("async_rst_data", tx.tx_data, 8'h31);
    push(8'h31, 16); push(8'h31, 23); push(8'h31, 30);
    rst_n = 1'b1;
    wait_cyc(36);
    check("post_rst_sent", sent_count, 3);

    check("exp_drained", exp_q.size(), 0);
    check("w_exp_drained", exp_w_q.size(), 0);
    check("w_no_err", timeout_err_w, 0);
    check("w_idle_end", busy_w, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
